// File: rtl/eim_slave_mem.sv
// EIM multiplexed address/data slave: DEPTH-word RAM window with auto-increment,
// read-prefetch wait generation and an exported control word. Burst beats on eim_bclk: EIM_BURST_EN.
module eim_slave_mem #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              eim_cs0_n,
  input  logic              eim_lba_n,
  input  logic              eim_wr_n,
  input  logic              eim_oe_n,
  input  logic              eim_bclk,
  input  logic [DATA_W-1:0] da_in,
  output logic [DATA_W-1:0] da_out,
  output logic              da_oe,
  output logic              eim_wait_n,
  output logic [DATA_W-1:0] ctrl_word,
  output logic [7:0]        err_cnt
);

  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StAddr, StWrite, StRead} state_e;

  state_e state_q, state_d;

  // Strobe vector order: {oe, wr, lba, cs}
  logic [3:0]        strb_sync [SYNC_STAGES];
  logic [DATA_W-1:0] da_sync   [SYNC_STAGES];
  logic [3:0]        strb_s, strb_q;
  logic [DATA_W-1:0] da_s;

  logic cs_s, wr_s;
  logic cs_rise, lba_fall, lba_rise;
  logic wr_beat, rd_beat_ev;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ctrl_q, da_out_q, rd_word;
  logic [7:0]        err_q;
  logic              fetch_q;
  logic              in_range;
  logic [MemAw-1:0]  mem_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic addr_load, wr_commit, rd_start, rd_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= '1;
        da_sync[i]   <= '0;
      end
      strb_q <= '1;
    end else begin
      strb_sync[0] <= {eim_oe_n, eim_wr_n, eim_lba_n, eim_cs0_n};
      da_sync[0]   <= da_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= strb_sync[i-1];
        da_sync[i]   <= da_sync[i-1];
      end
      strb_q <= strb_s;
    end
  end

  assign strb_s   = strb_sync[SYNC_STAGES-1];
  assign da_s     = da_sync[SYNC_STAGES-1];
  assign cs_s     = strb_s[0];
  assign wr_s     = strb_s[2];
  assign cs_rise  = strb_s[0] & ~strb_q[0];
  assign lba_fall = ~strb_s[1] & strb_q[1];
  assign lba_rise = strb_s[1] & ~strb_q[1];

`ifdef EIM_BURST_EN
  logic [SYNC_STAGES-1:0] bclk_sync;
  logic                   bclk_q;
  logic                   bclk_s;
  logic                   unused_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '1;
      bclk_q    <= 1'b1;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], eim_bclk};
      bclk_q    <= bclk_s;
    end
  end

  assign bclk_s      = bclk_sync[SYNC_STAGES-1];
  // In burst mode only bclk edges are beats; wr/oe edges just gate entry and exit.
  assign wr_beat     = bclk_s & ~bclk_q;
  assign rd_beat_ev  = bclk_s & ~bclk_q;
  assign unused_strb = ^{strb_s[3], strb_q[3:2]};
`else
  logic unused_bclk;

  assign wr_beat     = strb_s[2] & ~strb_q[2];
  assign rd_beat_ev  = strb_s[3] & ~strb_q[3];
  assign unused_bclk = eim_bclk;
`endif

  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    wr_commit = 1'b0;
    rd_start  = 1'b0;
    rd_beat   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (lba_fall && !cs_s) begin
          state_d   = StAddr;
          addr_load = 1'b1;
        end
      end
      StAddr: begin
        if (lba_rise) begin
          if (!wr_s) begin
            state_d = StWrite;
          end else begin
            state_d  = StRead;
            rd_start = 1'b1;
          end
        end
      end
      StWrite: wr_commit = wr_beat;
      StRead:  rd_beat   = rd_beat_ev;
      default: state_d   = StIdle;
    endcase
    // Deselect wins over everything except a write that completes in the same cycle.
    if (cs_rise) begin
      state_d   = StIdle;
      addr_load = 1'b0;
      rd_start  = 1'b0;
      rd_beat   = 1'b0;
    end
  end

  assign in_range = {1'b0, addr_q} < DepthLim;
  assign mem_idx  = addr_q[MemAw-1:0];

  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = (addr_q == '0) ? ctrl_q : mem[mem_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      ctrl_q   <= '0;
      err_q    <= '0;
      fetch_q  <= 1'b0;
      da_out_q <= '0;
    end else begin
      state_q <= state_d;

      if (addr_load) begin
        addr_q <= da_s[ADDR_W-1:0];
      end else if (wr_commit || rd_beat) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (wr_commit && in_range && addr_q == '0) begin
        ctrl_q <= da_s;
      end

      if ((wr_commit || rd_beat) && !in_range && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end

      // fetch_q marks the single wait cycle; the fetched word lands as it clears.
      if (cs_rise) begin
        fetch_q <= 1'b0;
      end else if (rd_start || rd_beat) begin
        fetch_q <= 1'b1;
      end else if (fetch_q) begin
        fetch_q  <= 1'b0;
        da_out_q <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_commit && in_range) begin
      mem[mem_idx] <= da_s;
    end
  end

  assign da_out     = da_out_q;
  assign da_oe      = (state_q == StRead) & ~eim_oe_n & ~eim_cs0_n;
  assign eim_wait_n = ~fetch_q;
  assign ctrl_word  = ctrl_q;
  assign err_cnt    = err_q;

endmodule
